// File: rtl/avs_regbank_pkg.sv
// avs_regbank_pkg -- definitions shared by the register bank and its channels.
//   op_e     : write operation selected by avs_s1_address[1:0]
//   ch_width : channel-index width, never narrower than one bit
package avs_regbank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,   // reg  = wd
        OP_SET  = 2'd1,   // reg |= wd
        OP_CLR  = 2'd2,   // reg &= ~wd
        OP_TGL  = 2'd3    // reg ^= wd
    } op_e;

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/avs_regbank_ch.sv
// avs_regbank_ch -- one channel register with byte-masked LOAD/SET/CLR/TGL.
// Ports:
//   csi_clk, csi_reset : clock, synchronous active-high reset
//   wr_en              : this channel is written at the next rising edge
//   op                 : operation (op_e encoding)
//   wdata, byteenable  : operand and per-byte enables
//   value              : current register contents
//   update             : high for one cycle after value actually changed
module avs_regbank_ch
    import avs_regbank_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  csi_clk,
    input  logic                  csi_reset,
    input  logic                  wr_en,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     value,
    output logic                  update
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] op_result;
    logic [DATA_W-1:0] merged;
    logic              changed;

    always_comb begin
        op_result = value;
        case (op)
            OP_LOAD: op_result = wdata;
            OP_SET:  op_result = value | wdata;
            OP_CLR:  op_result = value & ~wdata;
            OP_TGL:  op_result = value ^ wdata;
            default: op_result = value;
        endcase
    end

    // Disabled bytes keep their old contents.
    always_comb begin
        merged = value;
        for (int b = 0; b < BE_W; b++) begin
            if (byteenable[b]) begin
                merged[b*8 +: 8] = op_result[b*8 +: 8];
            end
        end
    end

    // A write that leaves the register unchanged must not strobe update.
    assign changed = wr_en && (merged != value);

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            value  <= RESET_VAL;
            update <= 1'b0;
        end else begin
            update <= changed;
            if (changed) begin
                value <= merged;
            end
        end
    end

endmodule

// File: rtl/avs_regbank.sv
// avs_regbank -- Avalon-MM slave bank of NUM_CH DATA_W-bit output registers.
// Ports:
//   csi_clk, csi_reset    : clock, synchronous active-high reset
//   avs_s1_address        : [ADDR_W-1:2] channel, [1:0] operation (op_e)
//   avs_s1_read/_write    : requests, accepted every cycle (no waitrequest)
//   avs_s1_writedata      : write operand
//   avs_s1_byteenable     : per-byte write enables
//   avs_s1_readdata/valid : read response, fixed latency 1
//   user_dataout          : channel c at [c*DATA_W +: DATA_W]
//   user_update           : bit c strobes for one cycle after channel c changed
//
// Handshake: a request is accepted on every rising edge where read or write is
// high. A write wins over a simultaneous read, which is dropped. An accepted read
// returns readdata with readdatavalid high for exactly the following cycle;
// readdata holds its last value while readdatavalid is low. Reset is applied
// combinationally to the response outputs so a read accepted just before reset
// never produces readdatavalid.
module avs_regbank
    import avs_regbank_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                NUM_CH    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               CH_W      = ch_width(NUM_CH),
    localparam int               ADDR_W    = CH_W + 2,
    localparam int               BE_W      = DATA_W / 8
) (
    input  logic                     csi_clk,
    input  logic                     csi_reset,
    input  logic [ADDR_W-1:0]        avs_s1_address,
    input  logic                     avs_s1_read,
    output logic [DATA_W-1:0]        avs_s1_readdata,
    output logic                     avs_s1_readdatavalid,
    input  logic                     avs_s1_write,
    input  logic [DATA_W-1:0]        avs_s1_writedata,
    input  logic [BE_W-1:0]          avs_s1_byteenable,
    output logic [NUM_CH*DATA_W-1:0] user_dataout,
    output logic [NUM_CH-1:0]        user_update
);

    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        op;
    logic              ch_ok;
    logic              rd_fire;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] upd_q;
    logic [DATA_W-1:0] ch_value [NUM_CH];
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_q;
    logic              rdv_q;

    assign ch_sel  = avs_s1_address[ADDR_W-1:2];
    assign op      = avs_s1_address[1:0];
    // Indices past NUM_CH exist when NUM_CH is not a power of two.
    assign ch_ok   = (32'(ch_sel) < 32'(NUM_CH));
    assign rd_fire = avs_s1_read && !avs_s1_write;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_en[c] = avs_s1_write && ch_ok && (ch_sel == CH_W'(c));

        avs_regbank_ch #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_ch (
            .csi_clk    (csi_clk),
            .csi_reset  (csi_reset),
            .wr_en      (wr_en[c]),
            .op         (op),
            .wdata      (avs_s1_writedata),
            .byteenable (avs_s1_byteenable),
            .value      (ch_value[c]),
            .update     (upd_q[c])
        );

        assign user_dataout[c*DATA_W +: DATA_W] = ch_value[c];
    end

    // Unmapped channels read as zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ok && (ch_sel == CH_W'(c))) begin
                rd_mux = ch_value[c];
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            rd_q  <= '0;
            rdv_q <= 1'b0;
        end else begin
            rdv_q <= rd_fire;
            if (rd_fire) begin
                rd_q <= rd_mux;
            end
        end
    end

    assign avs_s1_readdata      = csi_reset ? '0 : rd_q;
    assign avs_s1_readdatavalid = rdv_q && !csi_reset;
    assign user_update          = csi_reset ? '0 : upd_q;

endmodule

// File: doc/avs_regbank.md
AVS_REGBANK -- requirements
Module: avs_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each channel register; legal values 8, 16, 32.
REQ-002 SHALL have parameter NUM_CH, default 4: number of output channels; legal range 1..16.
REQ-003 SHALL have parameter RESET_VAL, default 0: value loaded into every channel on reset.
REQ-004 SHALL derive localparam CH_W = max(1, clog2(NUM_CH)), ADDR_W = CH_W+2 and BE_W = DATA_W/8.
REQ-005 SHALL have port csi_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port csi_reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port avs_s1_address, input, ADDR_W bits: [ADDR_W-1:2] selects the channel, [1:0] selects the operation.
REQ-008 SHALL have port avs_s1_read, input, 1 bit: read request.
REQ-009 SHALL have port avs_s1_readdata, output, DATA_W bits: read result.
REQ-010 SHALL have port avs_s1_readdatavalid, output, 1 bit: readdata qualifier.
REQ-011 SHALL have port avs_s1_write, input, 1 bit: write request.
REQ-012 SHALL have port avs_s1_writedata, input, DATA_W bits: write data.
REQ-013 SHALL have port avs_s1_byteenable, input, BE_W bits: per-byte write enables.
REQ-014 SHALL have port user_dataout, output, NUM_CH*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-015 SHALL have port user_update, output, NUM_CH bits: one-cycle strobe, bit c high in the cycle after channel c changes value.

Function
REQ-016 SHALL decode op = address[1:0] as follows: 0 = LOAD (reg = wd), 1 = SET (reg |= wd), 2 = CLR (reg &= ~wd), 3 = TGL (reg ^= wd).
REQ-017 SHALL apply every write op only to bytes whose byteenable bit is 1; other bytes SHALL be unchanged.
REQ-018 SHALL make a write visible on user_dataout at the first rising edge after avs_s1_write is sampled high (zero added latency).
REQ-019 SHALL return, for a read, the current register of the addressed channel for any op value, with fixed latency 1: avs_s1_readdatavalid high for exactly one cycle, one cycle after avs_s1_read is sampled.
REQ-020 SHALL hold avs_s1_readdata at its last value when avs_s1_readdatavalid is low.
REQ-021 SHALL, when read and write are asserted in the same cycle, perform the write and ignore the read (no readdatavalid).
REQ-022 SHALL, for a read in the cycle after a write to the same channel, return the post-write value.
REQ-023 SHALL ignore writes to a channel index >= NUM_CH, and SHALL answer reads of such an index with 0 and readdatavalid.
REQ-024 SHALL assert user_update[c] only if the register value actually changed; a write producing the same value (e.g. SET of bits already set, byteenable all 0) SHALL NOT strobe.
REQ-025 SHALL support back-to-back reads and writes every cycle with no wait states; the block has no waitrequest.

Reset
REQ-026 SHALL, while csi_reset is sampled high, load RESET_VAL into all channels, drive user_update, avs_s1_readdata and avs_s1_readdatavalid to 0, and ignore the bus.
REQ-027 SHALL, for a read accepted in the cycle before reset, suppress its readdatavalid.
REQ-028 SHALL NOT strobe user_update because of reset.

Structure
REQ-029 SHALL place the op encodings (OP_LOAD, OP_SET, OP_CLR, OP_TGL) in shared package avs_regbank_pkg.
REQ-030 SHALL implement one channel register as sub-module avs_regbank_ch, with byte-masked op logic and change detect, instantiated NUM_CH times by generate.
REQ-031 SHALL keep read mux and readdatavalid pipeline in the top module.

Verification
REQ-032 SHALL cover: reset with RESET_VAL=8'hA5 -> all user_dataout channels read 8'hA5, user_update=0, readdatavalid=0.
REQ-033 SHALL cover: LOAD ch2 8'h3C, then SET 8'h81, CLR 8'h0C, TGL 8'hFF -> ch2 = 8'h3C, 8'hBD, 8'hB1, 8'h4E; one user_update[2] strobe per write.
REQ-034 SHALL cover: DATA_W=32, LOAD ch1 32'h12345678 with byteenable 4'b0101 over 0 -> ch1 = 32'h00340078.
REQ-035 SHALL cover: write ch0 8'h55 then read ch0 next cycle -> readdata 8'h55 with readdatavalid one cycle after the read; simultaneous read+write -> no readdatavalid.
REQ-036 SHALL cover: NUM_CH=3, write channel 3 -> no output change; read channel 3 -> 0 with valid; SET 8'h01 on ch0 already 8'h01 -> no user_update.
REQ-037 SHALL cover: read issued, reset asserted next cycle -> no readdatavalid, all outputs at reset values.
